// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution, stride 1, zero padding 1, window built from two line buffers.
// Optional build macro CONV3X3_RELU_EN clamps negative results to zero after saturation.

module conv3x3_mac #(
    parameter int CIN   = 3,
    parameter int SHIFT = 13
) (
    input  logic [72*CIN-1:0] pix,
    input  logic [72*CIN-1:0] wts,
    output logic [7:0]        res
);
    localparam int AW = 17 + $clog2(9*CIN);
    localparam logic signed [AW-1:0] MAXV = 127;
    localparam logic signed [AW-1:0] MINV = -128;

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] shd;
    logic signed [16:0]   prod;

    always_comb begin
        acc  = '0;
        prod = '0;
        for (int t = 0; t < 9*CIN; t++) begin
            prod = $signed({1'b0, pix[8*t +: 8]}) * $signed(wts[8*t +: 8]);
            acc  = acc + AW'(prod);
        end
        shd = acc >>> SHIFT;
        if (shd > MAXV)      res = 8'h7f;
        else if (shd < MINV) res = 8'h80;
        else                 res = shd[7:0];
`ifdef CONV3X3_RELU_EN
        if (res[7]) res = 8'h00;
`endif
    end
endmodule

module conv3x3_stream #(
    parameter int  WIDTH  = 320,
    parameter int  HEIGHT = 320,
    parameter int  CIN    = 3,
    parameter int  COUT   = 8,
    parameter int  SHIFT  = 13,
    localparam int WAW    = (COUT > 1) ? $clog2(COUT) : 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic                wt_we,
    input  logic [WAW-1:0]      wt_addr,
    input  logic [72*CIN-1:0]   wt_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*CIN-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*COUT-1:0]   out_data,
    output logic                busy,
    output logic                done
);
    localparam int NPIX = WIDTH * HEIGHT;
    localparam int CW   = $clog2(NPIX + WIDTH + 2);
    localparam int XW   = $clog2(WIDTH);
    localparam int YW   = $clog2(HEIGHT);
    localparam int PW   = 8 * CIN;

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
    state_t state, state_nxt;

    logic [72*CIN-1:0] wt_ram [COUT];
    logic [PW-1:0]     lb0 [WIDTH];
    logic [PW-1:0]     lb1 [WIDTH];
    // Window columns are packed {bottom, middle, top}; win0 is the oldest (dx=0)
    logic [3*PW-1:0]   win0, win1, cur_col;
    logic [PW-1:0]     cur_pix;
    logic [CW-1:0]     in_cnt, out_cnt;
    logic [XW-1:0]     ic, cc;
    logic [YW-1:0]     cr;
    logic              adv, produce, out_acc, last_out;
    logic [72*CIN-1:0] taps;
    logic [COUT-1:0][7:0] res;

    assign cur_pix  = (state == FLUSH) ? '0 : in_data;
    assign cur_col  = {cur_pix, lb0[ic], lb1[ic]};
    assign busy     = (state != IDLE);
    assign out_acc  = out_valid && out_ready;
    assign last_out = out_acc && (out_cnt == CW'(NPIX - 1));

    always_comb begin
        in_ready = 1'b0;
        case (state)
            FILL:    in_ready = 1'b1;
            RUN:     in_ready = !out_valid || out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    // FLUSH self-clocks zero pixels until the last WIDTH+1 centres have been produced
    assign adv = (state == FILL && in_valid) ||
                 (state == RUN && in_valid && in_ready) ||
                 (state == FLUSH && (!out_valid || out_ready) && in_cnt < CW'(NPIX + WIDTH + 1));
    assign produce = adv && (state != FILL);

    // Out-of-frame taps are zeroed here so stale line-buffer data never reaches a MAC
    always_comb begin
        taps = '0;
        for (int c = 0; c < CIN; c++)
            for (int dy = 0; dy < 3; dy++)
                for (int dx = 0; dx < 3; dx++)
                    if (!((dy == 0 && cr == '0) || (dy == 2 && cr == YW'(HEIGHT - 1)) ||
                          (dx == 0 && cc == '0) || (dx == 2 && cc == XW'(WIDTH - 1))))
                        taps[8*(9*c + 3*dy + dx) +: 8] =
                            (dx == 0) ? win0[PW*dy + 8*c +: 8] :
                            (dx == 1) ? win1[PW*dy + 8*c +: 8] :
                                        cur_col[PW*dy + 8*c +: 8];
    end

    for (genvar f = 0; f < COUT; f++) begin : g_mac
        conv3x3_mac #(.CIN(CIN), .SHIFT(SHIFT)) u_mac (
            .pix (taps),
            .wts (wt_ram[f]),
            .res (res[f])
        );
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FILL;
            FILL:    if (adv && in_cnt == CW'(WIDTH)) state_nxt = RUN;
            RUN:     if (adv && in_cnt == CW'(NPIX - 1)) state_nxt = FLUSH;
            FLUSH:   if (last_out) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            in_cnt    <= '0;
            out_cnt   <= '0;
            ic        <= '0;
            cc        <= '0;
            cr        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == FLUSH) && last_out;
            if (state == IDLE && start) begin
                in_cnt  <= '0;
                out_cnt <= '0;
                ic      <= '0;
                cc      <= '0;
                cr      <= '0;
            end else begin
                if (adv) begin
                    in_cnt <= in_cnt + 1'b1;
                    ic     <= (ic == XW'(WIDTH - 1)) ? '0 : ic + 1'b1;
                end
                if (produce) begin
                    if (cc == XW'(WIDTH - 1)) begin
                        cc <= '0;
                        cr <= cr + 1'b1;
                    end else begin
                        cc <= cc + 1'b1;
                    end
                end
                if (out_acc) out_cnt <= out_cnt + 1'b1;
            end
            if (produce) begin
                out_valid <= 1'b1;
                out_data  <= res;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && wt_we && int'(wt_addr) < COUT) wt_ram[wt_addr] <= wt_data;
        if (adv) begin
            lb0[ic] <= cur_pix;
            lb1[ic] <= lb0[ic];
            win0    <= win1;
            win1    <= cur_col;
        end
    end
endmodule

// File: tb/tb_conv3x3_stream.sv
// Bench for conv3x3_stream: frame-level convolution model, one per-cycle compare process.
// Honours CONV3X3_RELU_EN in the model so either build can be checked.

module tb_conv3x3_stream;
    localparam int W = 4, H = 4, CIN = 1, COUT = 2, SHIFT = 0, N = W * H;

    logic        clk = 0, rstn = 0, start = 0, wt_we = 0;
    logic [0:0]  wt_addr = '0;
    logic [71:0] wt_data = '0;
    logic        in_valid = 0, in_ready;
    logic [7:0]  in_data = '0;
    logic        out_valid, out_ready = 1;
    logic [15:0] out_data;
    logic        busy, done;

    always #5 clk = ~clk;

    conv3x3_stream #(.WIDTH(W), .HEIGHT(H), .CIN(CIN), .COUT(COUT), .SHIFT(SHIFT)) dut (
        .clk(clk), .rstn(rstn), .start(start), .wt_we(wt_we), .wt_addr(wt_addr),
        .wt_data(wt_data), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    int          errors = 0, checks = 0;
    logic [15:0] exp_q[$];
    int          pix[N];
    int          wt[COUT][9];
    bit          stall_mode = 0;

    task automatic chk(string name, longint act, longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [7:0] conv(int r, int c, int f);
        int s = 0;
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++) begin
                int rr = r + dy - 1;
                int cl = c + dx - 1;
                if (rr >= 0 && rr < H && cl >= 0 && cl < W)
                    s += pix[rr*W + cl] * wt[f][3*dy + dx];
            end
        s = s >>> SHIFT;
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
`ifdef CONV3X3_RELU_EN
        if (s < 0) s = 0;
`endif
        return 8'(s);
    endfunction

    task automatic build_exp;
        logic [15:0] v;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            for (int f = 0; f < COUT; f++) v[8*f +: 8] = conv(i / W, i % W, f);
            exp_q.push_back(v);
        end
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic load_weights;
        for (int f = 0; f < COUT; f++) begin
            wt_we = 1; wt_addr = 1'(f);
            for (int k = 0; k < 9; k++) wt_data[8*k +: 8] = 8'(wt[f][k]);
            tick;
        end
        wt_we = 0;
    endtask

    task automatic feed(int p, bit gaps);
        int n  = 0;
        bit ok = 0;
        if (gaps) repeat ($urandom_range(0, 2)) tick;
        in_valid = 1; in_data = 8'(pix[p]);
        while (!ok && n < 200) begin
            @(negedge clk); ok = in_ready; tick; n++;
        end
        in_valid = 0;
        if (!ok) chk("in_accept_timeout", 0, 1);
    endtask

    task automatic wait_done;
        int n  = 0;
        bit ok = 0;
        while (!ok && n < 500) begin
            @(negedge clk); ok = done; n++;
        end
        chk("done_seen", ok, 1);
        chk("busy_at_done", busy, 0);
        chk("outputs_left", exp_q.size(), 0);
        tick;
    endtask

    task automatic run_frame(bit gaps);
        build_exp();
        start = 1; tick; start = 0;
        for (int p = 0; p < N; p++) feed(p, gaps);
        wait_done();
    endtask

    task automatic set_t1_weights;
        for (int k = 0; k < 9; k++) begin wt[0][k] = 1; wt[1][k] = (k == 4) ? 2 : 0; end
    endtask

    task automatic set_t2;
        for (int i = 0; i < N; i++) pix[i] = i;
        for (int k = 0; k < 9; k++) begin wt[0][k] = (k == 4) ? 1 : 0; wt[1][k] = (k == 5) ? 1 : 0; end
    endtask

    always @(posedge clk) begin
        #1;
        out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Single compare process: output stream, stall stability, latency, FLUSH in_ready
    int          acc_cnt = 0;
    bit          held = 0, seen_ov = 0;
    logic [15:0] held_data = '0;
    always @(negedge clk) begin
        if (!rstn) begin
            held = 0; acc_cnt = 0; seen_ov = 0;
        end else begin
            if (start && !busy) begin acc_cnt = 0; seen_ov = 0; end
            if (held) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, held_data);
            end
            if (out_valid && !seen_ov) begin
                seen_ov = 1;
                chk("first_out_latency", acc_cnt, W + 2);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
                else chk("out_data", out_data, exp_q.pop_front());
            end
            if (busy && acc_cnt == N) chk("flush_in_ready", in_ready, 0);
            if (in_valid && in_ready) acc_cnt++;
            held      = out_valid && !out_ready;
            held_data = out_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        repeat (3) tick;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rstn = 1; tick;

        // T1: flat frame, box filter and doubled centre
        for (int i = 0; i < N; i++) pix[i] = 1;
        set_t1_weights(); load_weights(); build_exp();
        chk("model_t1_corner", exp_q[0], 16'h0204);
        chk("model_t1_edge", exp_q[1], 16'h0206);
        chk("model_t1_inner", exp_q[5], 16'h0209);
        run_frame(0);

        // T2: raster ramp, identity on f0, right-neighbour on f1
        set_t2(); load_weights(); build_exp();
        chk("model_t2_mid", exp_q[6], 16'h0706);
        chk("model_t2_last", exp_q[15], 16'h000f);
        run_frame(0);

        // T3: saturation both ways
        for (int i = 0; i < N; i++) pix[i] = 255;
        for (int k = 0; k < 9; k++) begin wt[0][k] = 127; wt[1][k] = -128; end
        load_weights(); build_exp();
`ifdef CONV3X3_RELU_EN
        chk("model_t3_sat", exp_q[5], 16'h007f);
`else
        chk("model_t3_sat", exp_q[5], 16'h807f);
`endif
        run_frame(0);

        // T4: T2 under random backpressure and input gaps
        set_t2(); load_weights();
        stall_mode = 1;
        run_frame(1);
        stall_mode = 0;
        repeat (2) tick;

        // T5: abort mid-frame, dropped write during RUN, clean frames after
        build_exp();
        start = 1; tick; start = 0;
        for (int p = 0; p < 7; p++) feed(p, 0);
        #2 rstn = 0; #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        exp_q.delete();
        tick; rstn = 1; tick;
        build_exp();
        start = 1; tick; start = 0;
        for (int p = 0; p < 7; p++) feed(p, 0);
        wt_we = 1; wt_addr = 0; wt_data = {9{8'h7f}};
        tick;
        wt_we = 0;
        for (int p = 7; p < N; p++) feed(p, 0);
        wait_done();
        run_frame(0);

        // T6: bright frame then ramp frame back-to-back under the box filter
        set_t1_weights(); load_weights();
        for (int i = 0; i < N; i++) pix[i] = 200;
        run_frame(0);
        for (int i = 0; i < N; i++) pix[i] = i;
        build_exp();
        chk("model_t6_corner", exp_q[0], 16'h000a);
        run_frame(0);
        run_frame(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
